// File: rtl/mac_l1_seq.sv
// Layer-1 MAC sequencer: bias preload, pixel/weight address stream, latency-aligned MAC enable, result hold.
// Optional build macro MAC_ZERO_SKIP_EN gates mac_en on zero pixels and adds skip_cnt.
module mac_l1_seq #(
    parameter int N_PIX   = 784,
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        pixel_in,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_rd,
    output logic              mac_clr,
    output logic              mac_init_bias,
    output logic              mac_en,
    output logic              busy,
    output logic              out_valid,
`ifdef MAC_ZERO_SKIP_EN
    output logic [ADDR_W:0]   skip_cnt,
`endif
    input  logic              out_ready
);

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_RUN, S_DRAIN, S_HOLD} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [MEM_LAT-1:0] r_en_pipe, w_pipe_nxt;
    logic [MEM_LAT:0]   w_pipe_ext;
    logic               r_rd, r_clr, r_bias, r_busy, r_valid;
    logic               w_kill;

    assign w_kill     = abort && (r_state != S_IDLE);
    assign w_pipe_ext = {r_en_pipe, r_rd};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_pipe_nxt  = w_pipe_ext[MEM_LAT-1:0];
        if (w_kill) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
            w_pipe_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE:  if (start && !abort) w_state_nxt = S_BIAS;
                S_BIAS:  w_state_nxt = S_RUN;
                S_RUN: begin
                    // terminal compare, never relies on counter overflow
                    if (r_addr == LAST_ADDR) begin
                        w_state_nxt = S_DRAIN;
                        w_addr_nxt  = '0;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: if (w_pipe_nxt == '0) w_state_nxt = S_HOLD;
                S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_en_pipe <= '0;
            r_rd      <= 1'b0;
            r_clr     <= 1'b0;
            r_bias    <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_addr    <= w_addr_nxt;
            r_en_pipe <= w_pipe_nxt;
            r_rd      <= (w_state_nxt == S_RUN);
            r_clr     <= w_kill;
            r_bias    <= (w_state_nxt == S_BIAS);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_valid   <= (w_state_nxt == S_HOLD);
        end
    end

    assign pix_addr      = r_addr;
    assign pix_rd        = r_rd;
    assign mac_clr       = r_clr;
    assign mac_init_bias = r_bias;
    assign busy          = r_busy;
    assign out_valid     = r_valid;

`ifdef MAC_ZERO_SKIP_EN
    logic [ADDR_W:0] r_skip;
    logic            w_zero;

    // pixel_in is the RAM data for the current enable slot, so the gate cannot be registered
    assign w_zero   = (pixel_in == 8'd0);
    assign mac_en   = r_en_pipe[MEM_LAT-1] && !w_zero;
    assign skip_cnt = r_skip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               r_skip <= '0;
        else if (r_state == S_BIAS)             r_skip <= '0;
        else if (r_en_pipe[MEM_LAT-1] && w_zero) r_skip <= r_skip + (ADDR_W+1)'(1);
    end
`else
    logic w_unused_pixel;

    assign w_unused_pixel = ^pixel_in;
    assign mac_en         = r_en_pipe[MEM_LAT-1];
`endif

endmodule

// File: tb/tb_mac_l1_seq.sv
// Bench for mac_l1_seq: three configurations (784/1, 4/1, 4/3) checked every cycle against a schedule model.
module tb_mac_l1_seq;

    localparam int NI = 3;
    localparam logic [NI-1:0][15:0] NP = {16'd4, 16'd4, 16'd784};
    localparam logic [NI-1:0][3:0]  LT = {4'd3, 4'd1, 4'd1};

    // hand-computed per instance: addr peak, out_valid cycle, first mac_en cycle
    localparam int EXP_PEAK [NI] = '{783, 3, 3};
    localparam int EXP_VREL [NI] = '{787, 7, 9};
    localparam int EXP_ENREL[NI] = '{3, 3, 5};
`ifdef MAC_ZERO_SKIP_EN
    localparam int EXP_ENCNT[NI] = '{626, 2, 2};
    localparam int EXP_SKIP [NI] = '{158, 2, 2};
    localparam logic [3:0] EXP_MASK = 4'b1010;
`else
    localparam int EXP_ENCNT[NI] = '{784, 4, 4};
    localparam logic [3:0] EXP_MASK = 4'b1111;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       st[NI], ab[NI], rdy[NI];
    logic [7:0] pix[NI];
    logic [9:0] addr_o[NI];
    logic       rd_o[NI], clr_o[NI], ib_o[NI], en_o[NI], busy_o[NI], val_o[NI];
`ifdef MAC_ZERO_SKIP_EN
    logic [10:0] skip_o[NI];
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mac_l1_seq #(.N_PIX(int'(NP[g])), .ADDR_W(10), .MEM_LAT(int'(LT[g]))) u_dut (
            .clk(clk), .rst(rst), .start(st[g]), .abort(ab[g]), .pixel_in(pix[g]),
            .pix_addr(addr_o[g]), .pix_rd(rd_o[g]), .mac_clr(clr_o[g]),
            .mac_init_bias(ib_o[g]), .mac_en(en_o[g]), .busy(busy_o[g]),
            .out_valid(val_o[g]),
`ifdef MAC_ZERO_SKIP_EN
            .skip_cnt(skip_o[g]),
`endif
            .out_ready(rdy[g])
        );
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int k);
        case (k)
            0: return 8'd0;
            1: return 8'd5;
            2: return 8'd0;
            3: return 8'hFD;
            default: return (k % 5 == 0) ? 8'd0 : 8'((k % 100) + 1);
        endcase
    endfunction

    // schedule model: a run accepted at cycle t0 fixes every output as a function of (cycle - t0)
    bit         act[NI];
    bit         clr_e[NI];
    int         t0[NI], skip_e[NI];
    int         en_cnt[NI], peak[NI], vrel[NI], ibrel[NI], enrel[NI];
    logic [3:0] en_mask[NI];
    int         cyc;

    initial begin
        int n, l, rel, idx;
        bit w_en, nclr;
        logic [15:0] av, ev;
        cyc = 0;
        for (int i = 0; i < NI; i++) begin
            act[i] = 0; clr_e[i] = 0; t0[i] = 0; skip_e[i] = 0;
            en_cnt[i] = 0; peak[i] = 0; vrel[i] = -1; ibrel[i] = -1; enrel[i] = -1; en_mask[i] = '0;
            pix[i] = 8'd0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                n = int'(NP[i]); l = int'(LT[i]); rel = cyc - t0[i];
                w_en = act[i] && rel >= 2 + l && rel <= n + 1 + l;
                pix[i] = w_en ? pix_val(rel - 2 - l) : 8'd0;
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                n = int'(NP[i]); l = int'(LT[i]); rel = cyc - t0[i];
                w_en = act[i] && rel >= 2 + l && rel <= n + 1 + l;
                idx = rel - 2 - l;
`ifdef MAC_ZERO_SKIP_EN
                w_en = w_en && (pix[i] != 8'd0);
`endif
                ev[15] = act[i];
                ev[14] = act[i] && rel >= n + l + 2;
                ev[13] = act[i] && rel == 1;
                ev[12] = act[i] && rel >= 2 && rel <= n + 1;
                ev[11] = w_en;
                ev[10] = clr_e[i];
                ev[9:0] = ev[12] ? 10'(rel - 2) : 10'd0;
                av = {busy_o[i], val_o[i], ib_o[i], rd_o[i], en_o[i], clr_o[i], addr_o[i]};
                check($sformatf("outs[%0d]@%0d", i, cyc), 32'(av), 32'(ev));
`ifdef MAC_ZERO_SKIP_EN
                check($sformatf("skip_cnt[%0d]@%0d", i, cyc), 32'(skip_o[i]), 32'(skip_e[i]));
`endif
                if (act[i]) begin
                    if (en_o[i] === 1'b1) begin
                        en_cnt[i]++;
                        if (enrel[i] < 0) enrel[i] = rel;
                        if (idx >= 0 && idx < 4) en_mask[i][idx] = 1'b1;
                    end
                    if (rd_o[i] === 1'b1 && int'(addr_o[i]) > peak[i]) peak[i] = int'(addr_o[i]);
                    if (val_o[i] === 1'b1 && vrel[i] < 0) vrel[i] = rel;
                    if (ib_o[i] === 1'b1 && ibrel[i] < 0) ibrel[i] = rel;
                end
                if (!rst) begin
                    act[i] = 0; clr_e[i] = 0; skip_e[i] = 0;
                end else begin
                    nclr = 0;
                    if (act[i]) begin
                        if (rel == 1) skip_e[i] = 0;
                        else if (act[i] && rel >= 2 + l && rel <= n + 1 + l && pix[i] == 8'd0) skip_e[i]++;
                        if (ab[i]) begin
                            act[i] = 0; nclr = 1;
                        end else if (rel >= n + l + 2 && rdy[i]) begin
                            act[i] = 0;
                        end
                    end else if (st[i] && !ab[i]) begin
                        act[i] = 1; t0[i] = cyc;
                        en_cnt[i] = 0; peak[i] = 0; vrel[i] = -1; ibrel[i] = -1; enrel[i] = -1;
                        en_mask[i] = '0;
                    end
                    clr_e[i] = nclr;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int i, input int budget);
        int k;
        k = 0;
        while (val_o[i] !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("valid_seen[%0d]", i), 32'(val_o[i] === 1'b1), 1);
    endtask

    task automatic wait_addr2(input int i);
        int k;
        k = 0;
        while (!(rd_o[i] === 1'b1 && addr_o[i] == 10'd2) && k < 20) begin
            tick();
            k++;
        end
        check($sformatf("addr2_seen[%0d]", i), 32'(rd_o[i] === 1'b1 && addr_o[i] == 10'd2), 1);
    endtask

    task automatic run_normal(input int i);
        st[i] = 1'b1; tick(); st[i] = 1'b0;
        wait_valid(i, int'(NP[i]) + 20);
        repeat (20) tick();
        st[i] = 1'b1; tick(); st[i] = 1'b0;
        check($sformatf("peak_addr[%0d]", i), 32'(peak[i]), 32'(EXP_PEAK[i]));
        check($sformatf("valid_cycle[%0d]", i), 32'(vrel[i]), 32'(EXP_VREL[i]));
        check($sformatf("first_en[%0d]", i), 32'(enrel[i]), 32'(EXP_ENREL[i]));
        check($sformatf("bias_cycle[%0d]", i), 32'(ibrel[i]), 1);
        check($sformatf("en_count[%0d]", i), 32'(en_cnt[i]), 32'(EXP_ENCNT[i]));
        check($sformatf("en_mask[%0d]", i), 32'(en_mask[i]), 32'(EXP_MASK));
`ifdef MAC_ZERO_SKIP_EN
        check($sformatf("skip_total[%0d]", i), 32'(skip_o[i]), 32'(EXP_SKIP[i]));
`endif
        check($sformatf("valid_held[%0d]", i), 32'(val_o[i]), 1);
        rdy[i] = 1'b1; tick(); rdy[i] = 1'b0;
        check($sformatf("busy_after_hs[%0d]", i), 32'(busy_o[i]), 0);
    endtask

    task automatic run_abort(input int i);
        ab[i] = 1'b1; tick(); ab[i] = 1'b0;
        check($sformatf("idle_abort_clr[%0d]", i), 32'(clr_o[i]), 0);
        st[i] = 1'b1; ab[i] = 1'b1; tick(); st[i] = 1'b0; ab[i] = 1'b0;
        check($sformatf("start_abort_busy[%0d]", i), 32'(busy_o[i]), 0);
        st[i] = 1'b1; tick(); st[i] = 1'b0;
        wait_addr2(i);
        ab[i] = 1'b1; tick(); ab[i] = 1'b0;
        check($sformatf("abort_clr[%0d]", i), 32'(clr_o[i]), 1);
        check($sformatf("abort_busy[%0d]", i), 32'(busy_o[i]), 0);
        tick();
        check($sformatf("clr_one_cycle[%0d]", i), 32'(clr_o[i]), 0);
        repeat (int'(NP[i]) + 10) tick();
        check($sformatf("no_valid_after_abort[%0d]", i), 32'(vrel[i]), 32'hFFFF_FFFF);
    endtask

    task automatic run_restart(input int i);
        st[i] = 1'b1; tick(); st[i] = 1'b0;
        tick(); tick();
        st[i] = 1'b1; tick(); st[i] = 1'b0;
        wait_valid(i, int'(NP[i]) + 20);
        tick();
        check($sformatf("restart_valid_cycle[%0d]", i), 32'(vrel[i]), 32'(EXP_VREL[i]));
        check($sformatf("restart_peak[%0d]", i), 32'(peak[i]), 32'(EXP_PEAK[i]));
        st[i] = 1'b1; rdy[i] = 1'b1; tick(); st[i] = 1'b0; rdy[i] = 1'b0;
        tick();
        check($sformatf("hs_start_busy[%0d]", i), 32'(busy_o[i]), 0);
        check($sformatf("hs_start_bias[%0d]", i), 32'(ib_o[i]), 0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            st[i] = 1'b0; ab[i] = 1'b0; rdy[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) begin
            run_normal(i);
            run_abort(i);
            run_restart(i);
        end
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_l1_seq.md
Name: mac_l1_seq

Overview:
- Sequencer for the 32-wide layer-1 MAC array.
- On a start command it:
  - preloads the biases;
  - streams N_PIX pixel/weight addresses to the image and weight memories;
  - aligns the MAC enable with the memory read latency;
  - presents the finished accumulators to layer 2 with a valid/ready handshake.
- Sits between the top-level inference FSM and the MAC array, image RAM and weight ROM.

Parameters:
- N_PIX, 784, pixels per image; equals the number of MAC enable cycles.
- ADDR_W, 10, pixel/weight address width; must satisfy 2^ADDR_W >= N_PIX.
- MEM_LAT, 1, read latency of image RAM and weight ROM in cycles (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  begin one image; accepted only in IDLE.
- abort  in  1  cancel the current image; any state.
- pixel_in  in  8  current pixel (signed); used only with MAC_ZERO_SKIP_EN.
- pix_addr  out  ADDR_W  shared address to image RAM and weight ROM.
- pix_rd  out  1  read strobe for pix_addr.
- mac_clr  out  1  clear pulse to the MAC array.
- mac_init_bias  out  1  bias-preload pulse to the MAC array.
- mac_en  out  1  accumulate enable to the MAC array.
- busy  out  1  high from start acceptance until the result is accepted or aborted.
- out_valid  out  1  accumulators final and stable.
- out_ready  in  1  layer 2 has taken the accumulators.

Behaviour:
- All outputs registered. While rst=0: every output 0, state IDLE, pipeline empty.
- States: IDLE, BIAS, RUN, DRAIN, HOLD.
- IDLE:
  - Outputs low, pix_addr=0.
  - start=1 -> BIAS; busy=1 from the next cycle.
- BIAS:
  - Exactly one cycle with mac_init_bias=1 -> RUN.
- RUN:
  - pix_rd=1; pix_addr counts 0..N_PIX-1, one address per cycle.
  - After the cycle with addr N_PIX-1 -> DRAIN. pix_addr returns to 0.
- Enable pipeline:
  - mac_en equals pix_rd delayed by exactly MEM_LAT cycles (shift register).
  - This gives exactly N_PIX mac_en cycles, contiguous, never overlapping mac_init_bias.
- DRAIN:
  - Waits until the delay line is empty, so the last mac_en has been issued.
  - Next cycle -> HOLD with out_valid=1.
  - Timing: start sampled at edge 0 gives out_valid first high in cycle N_PIX+MEM_LAT+2 (787 at defaults).
- HOLD:
  - out_valid stays 1 and the MAC array receives no strobes until out_valid & out_ready.
  - On that handshake: out_valid=0, busy=0 -> IDLE next cycle.
- start handling:
  - start outside IDLE is ignored, not queued.
  - start and handshake in the same HOLD cycle: handshake completes, start is ignored.
- abort (highest priority after reset), in any non-IDLE state:
  - Next cycle -> IDLE with pix_rd, mac_en, mac_init_bias, out_valid, busy all 0.
  - Delay line flushed.
  - mac_clr=1 for exactly that one cycle.
  - abort in IDLE: no effect, no mac_clr.
  - abort together with start in IDLE: start is ignored.
- mac_clr is asserted only on abort; a normal run relies on mac_init_bias to overwrite the accumulators.
- Async reset mid-run: immediate return to IDLE; the MAC array contents are don't-care.
- The counter never wraps: RUN exits on the terminal compare, not on overflow.

Optional Feature:
- Macro: MAC_ZERO_SKIP_EN.
- When defined:
  - Beside the delayed pix_rd, mac_en is additionally gated low when pixel_in==0 in the enable cycle. This is a power saving; the accumulator result is unchanged.
  - Cycle timing and out_valid latency are identical to the non-skip build.
  - Adds output skip_cnt (ADDR_W+1 bits): number of suppressed enables in the last run. It is cleared in BIAS and held through HOLD.
- When undefined:
  - pixel_in is ignored and skip_cnt is absent.
  - mac_en is high for all N_PIX cycles.

Test Plan:
- N_PIX=4, MEM_LAT=1, reset then start pulse at cycle 0:
  - mac_init_bias high in cycle 1;
  - pix_addr 0,1,2,3 in cycles 2-5;
  - mac_en high in cycles 3-6;
  - out_valid high from cycle 7.
- Default params: count mac_en cycles = 784, pix_addr peak = 783, out_valid at cycle 787. With out_ready held low 20 cycles, out_valid stays 1 and no strobes occur; out_ready=1 -> busy=0 the next cycle.
- MEM_LAT=3, N_PIX=4: mac_en exactly 3 cycles after each pix_rd; out_valid at cycle 9.
- abort during RUN at pix_addr=2: next cycle state IDLE, mac_clr=1 for one cycle, no further mac_en, out_valid never rises; a following start runs normally.
- start re-pulsed during RUN and HOLD: no effect on addresses or timing. start and out_ready in the same HOLD cycle: returns to IDLE, no new run.
- MAC_ZERO_SKIP_EN, N_PIX=4, pixels {0,5,0,-3}: mac_en high only for indices 1 and 3; skip_cnt=2; out_valid still at cycle 7.
